question_gen: RTL and testbench

// - Produces the factorization puzzle that the player-entry block consumes. Picks three digits 1..9,

---
 rtl/question_gen.sv | 302 ++++++++++++++++++++++++++++++
 tb/tb_question_gen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/question_gen.sv
// ============================================================================
// question_gen
// ----------------------------------------------------------------------------
// Builds the factorization puzzle shown to the player. Three digits 1..9 are
// picked, either from a free-running Galois LFSR or from a forced input. The
// block multiplies them with a shift-add multiplier, converts the product to
// 3-digit BCD by double-dabble, and publishes
//   o_question = {BCD product (hundreds, tens, ones), digit A, digit B, digit C}.
// A fresh question is started on every entry into the READY game state
// (4'b0010). If READY is left while a question is being built, the build is
// abandoned.
//
// Ports
//   i_clk         system clock
//   i_rst         synchronous reset, active-high
//   i_state[3:0]  game state; 0010 READY, 0011 QUESTION, 0100 INPUT,
//                 0111 WRONG, others = result states
//   i_fix_en      sampled at start; 1 = use i_fix_digits instead of the LFSR
//   i_fix_digits  forced digits A=[11:8], B=[7:4], C=[3:0] (clamped to 1..9)
//   o_question    [23:12] BCD product, [11:0] BCD factors A,B,C
//   o_q_valid     o_question holds a completed question
//   o_busy        generation in progress
//
// Build option
//   QGEN_NO_REPEAT_EN  when defined, a random question whose product equals
//                      the previously published product is redrawn (at most
//                      three redraws, then it is accepted). Forced digits are
//                      never redrawn.
// ============================================================================
module question_gen #(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,   // must be nonzero
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,   // x^16+x^14+x^13+x^11+1
    parameter int unsigned       MAX_TRIES = 32
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [3:0]  i_state,
    input  logic        i_fix_en,
    input  logic [11:0] i_fix_digits,
    output logic [23:0] o_question,
    output logic        o_q_valid,
    output logic        o_busy
);

    localparam logic [3:0] ST_READY = 4'b0010;
    localparam int unsigned TRY_W   = $clog2(MAX_TRIES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAW,
        S_MUL,
        S_BCD,
        S_DONE
    } fsm_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    fsm_t              r_fsm;
    logic [3:0]        r_prev_state;
    logic [LFSR_W-1:0] r_lfsr;
    logic              r_fix_mode;
    logic [3:0]        r_dig_a;
    logic [3:0]        r_dig_b;
    logic [3:0]        r_dig_c;
    logic [1:0]        r_dig_idx;
    logic [TRY_W-1:0]  r_tries;
    logic [3:0]        r_cnt;
    logic [6:0]        r_ab;
    logic [9:0]        r_prod;
    logic [9:0]        r_bin;
    logic [11:0]       r_bcd;
    logic [23:0]       r_question;
    logic              r_q_valid;
    logic              r_busy;
`ifdef QGEN_NO_REPEAT_EN
    logic [11:0]       r_prev_prod;
    logic [1:0]        r_redraws;
`endif

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    fsm_t        w_fsm_next;
    logic        w_start;
    logic        w_abort;
    logic [LFSR_W-1:0] w_lfsr_next;
    logic [3:0]  w_cand;
    logic        w_cand_ok;
    logic        w_give_up;
    logic        w_draw_take;
    logic [3:0]  w_draw_digit;
    logic [6:0]  w_ab_next;
    logic [9:0]  w_prod_next;
    logic [11:0] w_bcd_adj;
    logic        w_redraw;

    function automatic logic [3:0] clamp_digit(input logic [3:0] d);
        if (d == 4'd0)
            return 4'd1;
        else if (d > 4'd9)
            return 4'd9;
        else
            return d;
    endfunction

    // A start is the first cycle READY is seen; it outranks an abort so that
    // dropping out of READY and coming straight back rebuilds the question.
    assign w_start = (i_state == ST_READY) && (r_prev_state != ST_READY);
    assign w_abort = r_busy && (i_state != ST_READY);

    // Right-shifting Galois LFSR.
    assign w_lfsr_next = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : '0);

    // Random digit draw: one candidate per cycle, fallback to 1 on the
    // MAX_TRIES-th reject of the same digit.
    assign w_cand       = r_lfsr[3:0];
    assign w_cand_ok    = (w_cand >= 4'd1) && (w_cand <= 4'd9);
    assign w_give_up    = (r_tries == TRY_W'(MAX_TRIES - 1));
    assign w_draw_take  = w_cand_ok || w_give_up;
    assign w_draw_digit = w_cand_ok ? w_cand : 4'd1;

    // Shift-add multiplier: counts 0..3 build A*B from the bits of B,
    // counts 4..7 build (A*B)*C from the bits of C. r_cnt[1:0] is the bit index
    // in both phases.
    assign w_ab_next   = r_ab + (r_dig_b[r_cnt[1:0]] ? ({3'b000, r_dig_a} << r_cnt[1:0]) : 7'd0);
    assign w_prod_next = r_prod + (r_dig_c[r_cnt[1:0]] ? ({3'b000, r_ab} << r_cnt[1:0]) : 10'd0);

    // Double-dabble correction applied before every shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int n = 0; n < 3; n++) begin
            if (r_bcd[n*4 +: 4] >= 4'd5)
                w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
        end
    end

`ifdef QGEN_NO_REPEAT_EN
    assign w_redraw = !r_fix_mode && (r_bcd == r_prev_prod) && (r_redraws != 2'd3);
`else
    assign w_redraw = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    // NOTE: every signal written in always_comb gets a default first so that no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        w_fsm_next = r_fsm;
        case (r_fsm)
            S_IDLE: w_fsm_next = S_IDLE;
            S_DRAW: begin
                if (r_fix_mode || (w_draw_take && (r_dig_idx == 2'd2)))
                    w_fsm_next = S_MUL;
            end
            S_MUL: begin
                if (r_cnt == 4'd7)
                    w_fsm_next = S_BCD;
            end
            S_BCD: begin
                if (r_cnt == 4'd9)
                    w_fsm_next = S_DONE;
            end
            S_DONE:  w_fsm_next = w_redraw ? S_DRAW : S_IDLE;
            default: w_fsm_next = S_IDLE;
        endcase

        if (w_start)
            w_fsm_next = S_DRAW;
        else if (w_abort)
            w_fsm_next = S_IDLE;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values of the others, independent of
    // statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst)
            r_fsm <= S_IDLE;
        else
            r_fsm <= w_fsm_next;
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_prev_state <= 4'b0000;
            r_lfsr       <= SEED;
            r_fix_mode   <= 1'b0;
            r_dig_a      <= 4'd0;
            r_dig_b      <= 4'd0;
            r_dig_c      <= 4'd0;
            r_dig_idx    <= 2'd0;
            r_tries      <= '0;
            r_cnt        <= 4'd0;
            r_ab         <= 7'd0;
            r_prod       <= 10'd0;
            r_bin        <= 10'd0;
            r_bcd        <= 12'd0;
            r_question   <= 24'd0;
            r_q_valid    <= 1'b0;
            r_busy       <= 1'b0;
`ifdef QGEN_NO_REPEAT_EN
            r_prev_prod  <= 12'd0;
            r_redraws    <= 2'd0;
`endif
        end else begin
            // Free-running so that player timing feeds the draw.
            r_lfsr       <= w_lfsr_next;
            r_prev_state <= i_state;

            // Phase counter restarts on every FSM transition.
            if (w_fsm_next != r_fsm)
                r_cnt <= 4'd0;
            else if ((r_fsm == S_MUL) || (r_fsm == S_BCD))
                r_cnt <= r_cnt + 4'd1;

            if (w_start) begin
                r_question <= 24'd0;
                r_q_valid  <= 1'b0;
                r_busy     <= 1'b1;
                r_fix_mode <= i_fix_en;
                r_dig_idx  <= 2'd0;
                r_tries    <= '0;
`ifdef QGEN_NO_REPEAT_EN
                r_redraws  <= 2'd0;
`endif
            end else if (w_abort) begin
                // Question and valid were already cleared by the start.
                r_busy <= 1'b0;
            end else begin
                case (r_fsm)
                    S_DRAW: begin
                        if (r_fix_mode) begin
                            r_dig_a <= clamp_digit(i_fix_digits[11:8]);
                            r_dig_b <= clamp_digit(i_fix_digits[7:4]);
                            r_dig_c <= clamp_digit(i_fix_digits[3:0]);
                        end else if (w_draw_take) begin
                            case (r_dig_idx)
                                2'd0:    r_dig_a <= w_draw_digit;
                                2'd1:    r_dig_b <= w_draw_digit;
                                default: r_dig_c <= w_draw_digit;
                            endcase
                            r_dig_idx <= r_dig_idx + 2'd1;
                            r_tries   <= '0;
                        end else begin
                            r_tries <= r_tries + 1'b1;
                        end
                        if (w_fsm_next == S_MUL) begin
                            r_ab   <= 7'd0;
                            r_prod <= 10'd0;
                        end
                    end
                    S_MUL: begin
                        if (r_cnt < 4'd4) begin
                            r_ab <= w_ab_next;
                        end else begin
                            r_prod <= w_prod_next;
                        end
                        // Hand the finished product straight to the converter.
                        if (r_cnt == 4'd7) begin
                            r_bin <= w_prod_next;
                            r_bcd <= 12'd0;
                        end
                    end
                    S_BCD: begin
                        {r_bcd, r_bin} <= {w_bcd_adj[10:0], r_bin, 1'b0};
                    end
                    S_DONE: begin
                        if (w_redraw) begin
`ifdef QGEN_NO_REPEAT_EN
                            r_redraws <= r_redraws + 2'd1;
`endif
                            r_dig_idx <= 2'd0;
                            r_tries   <= '0;
                        end else begin
                            r_question <= {r_bcd, r_dig_a, r_dig_b, r_dig_c};
                            r_q_valid  <= 1'b1;
                            r_busy     <= 1'b0;
`ifdef QGEN_NO_REPEAT_EN
                            r_prev_prod <= r_bcd;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign o_question = r_question;
    assign o_q_valid  = r_q_valid;
    assign o_busy     = r_busy;

endmodule

// File: tb/tb_question_gen.sv
// ============================================================================
// tb_question_gen
// ----------------------------------------------------------------------------
// Directed bench for question_gen. Edges are numbered from the start edge
// (edge 0, the first rising edge that sees READY after a non-READY state).
// Outputs are sampled 1 time unit after each rising edge.
// ============================================================================
`timescale 1ns/1ps
module tb_question_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state;
    logic        fix_en;
    logic [11:0] fix_digits;
    logic [23:0] question;
    logic        q_valid;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    question_gen dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_state      (state),
        .i_fix_en     (fix_en),
        .i_fix_digits (fix_digits),
        .o_question   (question),
        .o_q_valid    (q_valid),
        .o_busy       (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves READY for one edge, then returns; on exit edge 0 has just passed.
    task automatic do_start(input logic fe, input logic [11:0] digits);
        fix_en     = fe;
        fix_digits = digits;
        state      = 4'b0000;
        tick();
        state      = 4'b0010;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; state = 4'b0000; fix_en = 1'b0; fix_digits = 12'h000;
        tick();
        rst = 1'b0;
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_outputs got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
        repeat (50) tick();
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_hold got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
    endtask

    task automatic test_fixed_latency();
        do_start(1'b1, 12'h999);
        for (int e = 0; e < 20; e++) begin
            if (e > 0) tick();
            total++;
            if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b1}) begin
                bad++;
                $display("FAIL latency_busy edge=%0d got q=%h v=%b b=%b want q=000000 v=0 b=1", e, question, q_valid, busy);
            end
        end
        tick(); // edge 20
        total++;
        if ({question, q_valid, busy} !== {24'h729999, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL latency_done got q=%h v=%b b=%b want q=729999 v=1 b=0", question, q_valid, busy);
        end
    endtask

    task automatic test_fixed_values();
        logic [11:0] din [5];
        logic [23:0] dout [5];
        din[0] = 12'h234; dout[0] = 24'h024234;
        din[1] = 12'h111; dout[1] = 24'h001111;
        din[2] = 12'h0A5; dout[2] = 24'h045195;
        din[3] = 12'h8F0; dout[3] = 24'h072891;
        din[4] = 12'h519; dout[4] = 24'h045519;
        for (int k = 0; k < 5; k++) begin
            do_start(1'b1, din[k]);
            repeat (20) tick();
            total++;
            if ({question, q_valid, busy} !== {dout[k], 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL fixed_value in=%h got q=%h v=%b b=%b want q=%h v=1 b=0", din[k], question, q_valid, busy, dout[k]);
            end
        end
    endtask

    task automatic test_hold_and_reset();
        logic [3:0] seq [4];
        seq[0] = 4'b0011; seq[1] = 4'b0100; seq[2] = 4'b0111; seq[3] = 4'b1010;
        do_start(1'b1, 12'h999);
        repeat (20) tick();
        for (int k = 0; k < 4; k++) begin
            state = seq[k];
            repeat (3) tick();
            total++;
            if ({question, q_valid, busy} !== {24'h729999, 1'b1, 1'b0}) begin
                bad++;
                $display("FAIL hold state=%b got q=%h v=%b b=%b want q=729999 v=1 b=0", seq[k], question, q_valid, busy);
            end
        end
        // Next generation, reset on its edge 12.
        state = 4'b0010;
        tick(); // edge 0
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL restart_clear got q=%h v=%b b=%b want q=000000 v=0 b=1", question, q_valid, busy);
        end
        repeat (11) tick(); // edge 11
        rst = 1'b1; state = 4'b0000;
        tick(); // edge 12
        rst = 1'b0;
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midrun_reset got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
        repeat (25) tick();
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL post_reset_idle got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
    endtask

    task automatic test_abort();
        do_start(1'b1, 12'h876);
        repeat (5) tick(); // edge 5
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL abort_pre got b=%b want b=1", busy);
        end
        state = 4'b0011;
        tick(); // edge 6
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL abort_edge got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
        repeat (30) tick();
        total++;
        if ({question, q_valid, busy} !== {24'h000000, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL abort_hold got q=%h v=%b b=%b want q=000000 v=0 b=0", question, q_valid, busy);
        end
        state = 4'b0010;
        tick(); // edge 0 of the retry
        repeat (20) tick();
        total++;
        if ({question, q_valid, busy} !== {24'h336876, 1'b1, 1'b0}) begin
            bad++;
            $display("FAIL abort_retry got q=%h v=%b b=%b want q=336876 v=1 b=0", question, q_valid, busy);
        end
    endtask

    task automatic test_random();
        int a, b, c, p, n;
        logic [11:0] exp_bcd;
        for (int i = 0; i < 200; i++) begin
            fix_en = 1'b0;
            state  = 4'b0000;
            repeat (1 + (i % 3)) tick();
            state = 4'b0010;
            n = 0;
            do begin
                tick();
                n++;
            end while (!q_valid && n < 700);
            total++;
            if (q_valid !== 1'b1) begin
                bad++;
                $display("FAIL random_timeout entry=%0d got v=%b want v=1 within 700 cycles", i, q_valid);
                break;
            end
            a = int'(question[11:8]);
            b = int'(question[7:4]);
            c = int'(question[3:0]);
            total++;
            if (a < 1 || a > 9 || b < 1 || b > 9 || c < 1 || c > 9) begin
                bad++;
                $display("FAIL random_digits entry=%0d got %h want each digit 1..9", i, question[11:0]);
            end
            p = a * b * c;
            exp_bcd = {4'((p / 100) % 10), 4'((p / 10) % 10), 4'(p % 10)};
            total++;
            if (question[23:12] !== exp_bcd) begin
                bad++;
                $display("FAIL random_product entry=%0d got %h want %h", i, question[23:12], exp_bcd);
            end
        end
        state = 4'b0000;
        tick();
    endtask

    initial begin
        rst = 1'b1; state = 4'b0000; fix_en = 1'b0; fix_digits = 12'h000;
        test_reset();
        test_fixed_latency();
        test_fixed_values();
        test_hold_and_reset();
        test_abort();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
